// File: rtl/reg_ctx_xfer_pkg.sv
// Shared types for the register-context save/restore engine.
package reg_ctx_xfer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSave,
        StRstRd,
        StRstWr,
        StDone
    } state_e;

    localparam logic DIR_SAVE    = 1'b0;
    localparam logic DIR_RESTORE = 1'b1;

endpackage

// File: rtl/reg_ctx_xfer.sv
// Context save/restore engine: streams a register range to data memory (save)
// or reads it back from memory into the register file (restore).
module reg_ctx_xfer
    import reg_ctx_xfer_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned D  = 4,
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          dir,
    input  logic [AW-1:0] base_addr,
    input  logic [D-1:0]  first_reg,
    input  logic [D-1:0]  last_reg,
    output logic          busy,
    output logic          done,
    output logic [D-1:0]  reg_from_number,
    input  logic [W-1:0]  reg_out,
    output logic          reg_write_en,
    output logic [D-1:0]  reg_write_number,
    output logic [W-1:0]  reg_write_data,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [W-1:0]  mem_wdata,
    input  logic [W-1:0]  mem_rdata,
    input  logic          mem_ack
);

    state_e        state_q, state_d;
    logic [D-1:0]  cur_q, cur_d;
    logic [D-1:0]  last_q, last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [W-1:0]  buf_q, buf_d;
    logic          at_last;

    assign at_last = (cur_q == last_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (dir == DIR_RESTORE) ? StRstRd : StSave;
                end
            end
            StSave: begin
                if (mem_ack && at_last) begin
                    state_d = StDone;
                end
            end
            StRstRd: begin
                if (mem_ack) begin
                    state_d = StRstWr;
                end
            end
            StRstWr: begin
                state_d = at_last ? StDone : StRstRd;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output logic: everything is decoded from the current state so that an
    // asynchronous reset drops mem_req and the strobes immediately.
    always_comb begin
        busy             = 1'b0;
        done             = 1'b0;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        reg_from_number  = '0;
        reg_write_en     = 1'b0;
        reg_write_number = '0;
        reg_write_data   = '0;
        unique case (state_q)
            StIdle: begin
            end
            StSave: begin
                busy            = 1'b1;
                mem_req         = 1'b1;
                mem_we          = 1'b1;
                mem_addr        = addr_q;
                reg_from_number = cur_q;
                mem_wdata       = reg_out;
            end
            StRstRd: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = addr_q;
            end
            StRstWr: begin
                busy             = 1'b1;
                reg_write_en     = 1'b1;
                reg_write_number = cur_q;
                reg_write_data   = buf_q;
            end
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Datapath: register index and memory address advance together, both
    // wrapping naturally at their own widths.
    always_comb begin
        cur_d  = cur_q;
        last_d = last_q;
        addr_d = addr_q;
        buf_d  = buf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cur_d  = first_reg;
                    last_d = last_reg;
                    addr_d = base_addr;
                end
            end
            StSave: begin
                if (mem_ack && !at_last) begin
                    cur_d  = cur_q + D'(1);
                    addr_d = addr_q + AW'(1);
                end
            end
            StRstRd: begin
                if (mem_ack) begin
                    buf_d = mem_rdata;
                end
            end
            StRstWr: begin
                if (!at_last) begin
                    cur_d  = cur_q + D'(1);
                    addr_d = addr_q + AW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q  <= '0;
            last_q <= '0;
            addr_q <= '0;
            buf_q  <= '0;
        end else begin
            cur_q  <= cur_d;
            last_q <= last_d;
            addr_q <= addr_d;
            buf_q  <= buf_d;
        end
    end

endmodule

// File: tb/tb_reg_ctx_xfer.sv
// Scoreboard bench for reg_ctx_xfer: randomized transfers against a
// register/memory reference model, with a monitor that retires expectations.
module tb_reg_ctx_xfer;
    import reg_ctx_xfer_pkg::*;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          dir = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [D-1:0]  first_reg = '0;
    logic [D-1:0]  last_reg = '0;
    logic          busy, done;
    logic [D-1:0]  reg_from_number;
    logic [W-1:0]  reg_out;
    logic          reg_write_en;
    logic [D-1:0]  reg_write_number;
    logic [W-1:0]  reg_write_data;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;
    logic          mem_ack = 1'b0;

    reg_ctx_xfer #(.W(W), .D(D), .AW(AW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .dir              (dir),
        .base_addr        (base_addr),
        .first_reg        (first_reg),
        .last_reg         (last_reg),
        .busy             (busy),
        .done             (done),
        .reg_from_number  (reg_from_number),
        .reg_out          (reg_out),
        .reg_write_en     (reg_write_en),
        .reg_write_number (reg_write_number),
        .reg_write_data   (reg_write_data),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_ack          (mem_ack)
    );

    always #5 clk = ~clk;

    // Environment (written by the DUT) and reference model (written by the bench)
    logic [W-1:0] regs_env [16];
    logic [W-1:0] mem_env [256];
    logic [W-1:0] model_regs [16];
    logic [W-1:0] model_mem [256];

    assign reg_out   = regs_env[reg_from_number];
    assign mem_rdata = mem_env[mem_addr];

    typedef struct {
        int         kind;  // 0 mem write, 1 reg write (after mem read), 2 done
        logic [7:0] addr;
        logic [3:0] idx;
        logic [7:0] data;
        int         cyc;   // expected done cycle, -1 when not timed
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   ack_fixed = 0;   // -1: random wait 0..2
    bit   req_active = 1'b0;
    int   wait_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst_n) begin
            if (mem_req && mem_we && mem_ack) mem_env[mem_addr] <= mem_wdata;
            if (reg_write_en) regs_env[reg_write_number] <= reg_write_data;
        end
    end

    // Memory acknowledge generator
    always @(posedge clk) begin
        #1;
        if (!mem_req) begin
            mem_ack = 1'b0;
            req_active = 1'b0;
        end else begin
            if (!req_active) begin
                wait_cnt = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 2));
                req_active = 1'b1;
            end
            if (wait_cnt == 0) begin
                mem_ack = 1'b1;
                req_active = 1'b0;
            end else begin
                mem_ack = 1'b0;
                wait_cnt--;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin : mon
        exp_t h;
        if (rst_n) begin
            if (mem_req || reg_write_en) check("req_with_wen", 64'(mem_req & reg_write_en), 64'd0);
            if (mem_req) begin
                if (sb.size() == 0) check("unexpected_mem_req", 64'(mem_req), 64'd0);
                else begin
                    h = sb[0];
                    check("mem_req_fields",
                          {46'd0, 1'b1, mem_we, mem_addr, (mem_we ? mem_wdata : 8'h00)},
                          {46'd0, (h.kind != 2), (h.kind == 0), h.addr,
                           (h.kind == 0 ? h.data : 8'h00)});
                    if (mem_ack && mem_we && h.kind == 0) begin
                        model_mem[h.addr] = h.data;
                        void'(sb.pop_front());
                    end
                end
            end
            if (reg_write_en) begin
                if (sb.size() == 0) check("unexpected_reg_write", 64'(reg_write_en), 64'd0);
                else begin
                    h = sb[0];
                    check("reg_write_fields", {51'd0, 1'b1, reg_write_number, reg_write_data},
                          {51'd0, (h.kind == 1), h.idx, h.data});
                    if (h.kind == 1) begin
                        model_regs[h.idx] = h.data;
                        void'(sb.pop_front());
                    end
                end
            end
            if (done) begin
                if (sb.size() == 0) check("unexpected_done", 64'(done), 64'd0);
                else begin
                    h = sb[0];
                    check("done_kind_busy", {62'd0, (h.kind == 2), busy}, 64'd3);
                    if (h.kind == 2) begin
                        if (h.cyc >= 0) check("done_cycle", 64'(cyc), 64'(h.cyc));
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the following negedge.
    task automatic issue(input bit d, input int base, input int first, input int last);
        int n;
        exp_t e;
        n = ((last - first) & 15) + 1;
        for (int k = 0; k < n; k++) begin
            e.kind = d ? 1 : 0;
            e.idx  = 4'((first + k) & 15);
            e.addr = 8'((base + k) & 255);
            e.data = d ? model_mem[e.addr] : model_regs[e.idx];
            e.cyc  = -1;
            sb.push_back(e);
        end
        e.kind = 2;
        e.addr = '0;
        e.idx  = '0;
        e.data = '0;
        e.cyc  = (ack_fixed == 0) ? cyc + (d ? 2 * n : n) + 1 : -1;
        sb.push_back(e);
        start     = 1'b1;
        dir       = d;
        base_addr = 8'(base);
        first_reg = 4'(first);
        last_reg  = 4'(last);
        @(posedge clk);
        #1;
        start     = 1'b0;
        dir       = 1'($urandom);
        base_addr = 8'($urandom);
        first_reg = 4'($urandom);
        last_reg  = 4'($urandom);
        @(negedge clk);
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (sb.size() != 0) begin
            check("timeout_pending", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
        check("idle_after_done", {60'd0, busy, done, mem_req, reg_write_en}, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            regs_env[i] = 8'($urandom);
            model_regs[i] = regs_env[i];
        end
        for (int i = 0; i < 256; i++) begin
            mem_env[i] = 8'($urandom);
            model_mem[i] = mem_env[i];
        end
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {27'd0, busy, done, mem_req, mem_we, reg_write_en, reg_from_number,
               reg_write_number, reg_write_data, mem_addr, mem_wdata}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Save regs 0..3 to 0x80, zero-wait
        for (int i = 0; i < 4; i++) begin
            regs_env[i] = 8'(8'h11 * (i + 1));
            model_regs[i] = regs_env[i];
        end
        ack_fixed = 0;
        issue(1'b0, 'h80, 0, 3);
        wait_idle();
        for (int i = 0; i < 4; i++) check("save_mem_content", 64'(mem_env[8'h80 + i]),
                                          64'(8'h11 * (i + 1)));

        // Restore regs 2..4 from 0x40..0x42
        for (int i = 0; i < 3; i++) begin
            mem_env[8'h40 + i] = 8'(8'hA0 + i);
            model_mem[8'h40 + i] = mem_env[8'h40 + i];
        end
        issue(1'b1, 'h40, 2, 4);
        wait_idle();
        for (int i = 0; i < 3; i++) check("restore_reg_content", 64'(regs_env[2 + i]),
                                          64'(8'hA0 + i));

        // Single register, ack delayed 3 cycles
        ack_fixed = 3;
        issue(1'b0, 'h30, 5, 5);
        wait_idle();

        // Index and address wrap
        ack_fixed = 0;
        issue(1'b0, 'hFE, 14, 1);
        wait_idle();

        // Reset during RST_RD of a 4-register restore
        begin
            int t = 0;
            issue(1'b1, 'h20, 8, 11);
            while (!reg_write_en && t < 50) begin
                @(negedge clk);
                t++;
            end
            check("abort_first_write_seen", 64'(reg_write_en), 64'd1);
            @(negedge clk);
            check("abort_in_rst_rd", 64'({mem_req, mem_we}), 64'd2);
            #1 rst_n = 1'b0;
            #1 check("abort_async_drop", 64'({busy, mem_req}), 64'd0);
            sb.delete();
            @(negedge clk);
            rst_n = 1'b1;
            repeat (6) @(negedge clk);
            check("abort_stays_idle", {61'd0, busy, done, reg_write_en}, 64'd0);
        end

        // start while busy must be ignored
        ack_fixed = -1;
        issue(1'b0, 'h10, 3, 9);
        @(negedge clk);
        start = 1'b1;
        dir = DIR_RESTORE;
        base_addr = 8'h99;
        first_reg = 4'd0;
        last_reg = 4'd15;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();

        // Randomized back-to-back transfers
        for (int i = 0; i < 24; i++) begin
            ack_fixed = ($urandom_range(0, 1) == 0) ? 0 : -1;
            issue(1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)));
            wait_idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
